fft_ref_stream_ctrl: RTL and testbench

//  Sequencer for the golden FFT-output ROM (sync read, 1-cycle latency) in the Burst_FFT_IFFT apply bench.
//  On a start pulse it walks the ROM address space, absorbs the ROM read latency and replays
//  NUM_FRAMES frames of FRAME_LEN words as a valid/ready stream.

---
 rtl/fft_ref_stream_pkg.sv | 17 +
 rtl/fft_ref_stream_ctrl_skid_fifo2.sv | 59 +++++
 rtl/fft_ref_stream_ctrl.sv | 159 +++++++++++++++
 tb/tb_fft_ref_stream_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ref_stream_pkg.sv
// Shared types for the golden-FFT reference stream sequencer and its skid FIFO.
package fft_ref_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // FIFO entries are packed {sof, last, data}; sideband bit positions sit above the data field.
  localparam int SB_BITS     = 2;
  localparam int SB_SOF      = 1;
  localparam int SB_LAST     = 0;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fft_ref_stream_ctrl_skid_fifo2.sv
// Two-entry registered FIFO used to absorb ROM read latency under stream backpressure.
module ref_skid_fifo2 #(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_ref_stream_ctrl.sv
// Replays NUM_FRAMES frames of FRAME_LEN words from a sync-read golden ROM as a
// valid/ready stream with sof/last framing.
module fft_ref_stream_ctrl
  import fft_ref_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int NUM_FRAMES = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic [ADDR_WIDTH-1:0]  rom_addr_o,
  input  logic [DATA_WIDTH-1:0]  rom_data_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int TOTAL = FRAME_LEN * NUM_FRAMES;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int WIN_W = $clog2(FRAME_LEN);
  localparam int FW    = DATA_WIDTH + SB_BITS;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   issued_q, issued_d;
  logic [SB_BITS-1:0]     sb_iss_q, sb_iss_d;
  logic                   inflight_q, inflight_d;
  logic [SB_BITS-1:0]     sb_inf_q, sb_inf_d;

  logic          pop, push, issue, accept_start, final_beat;
  logic          fifo_full, fifo_empty;
  logic [1:0]    fifo_cnt;
  logic [2:0]    credit_use;
  logic [FW-1:0] fifo_rdata;

  // rom_data_i stays stable while rom_addr is unchanged, so an unpushed word can
  // wait on the ROM output; the credit keeps a new issue from disturbing it.
  assign pop        = m_valid_o && m_ready_i;
  assign push       = inflight_q && (!fifo_full || pop) && !abort_i;
  assign credit_use = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == S_FETCH) && !abort_i && (credit_use < 3'd2);
  assign accept_start = (state_q == S_IDLE) && start_i && !abort_i;
  assign final_beat = pop && m_last_o && (fcnt_q == FRAME_CNT_W'(NUM_FRAMES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    if (pop && m_last_o && !abort_i) begin
      fcnt_d = fcnt_q + 1'b1;
    end
    if (issue) begin
      addr_d = ADDR_WIDTH'(idx_q);
      idx_d  = idx_q + 1'b1;
      win_d  = (win_q == WIN_W'(FRAME_LEN - 1)) ? '0 : win_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          win_d   = '0;
          fcnt_d  = '0;
        end
      end
      S_FETCH: if (issue && (idx_q == IDX_W'(TOTAL - 1))) state_d = S_DRAIN;
      S_DRAIN: if (final_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    issued_d   = 1'b0;
    sb_iss_d   = sb_iss_q;
    inflight_d = inflight_q;
    sb_inf_d   = sb_inf_q;
    if (abort_i) begin
      inflight_d = 1'b0;
    end else begin
      issued_d = issue;
      if (issue) begin
        sb_iss_d = {win_q == '0, win_q == WIN_W'(FRAME_LEN - 1)};
      end
      if (issued_q) begin
        inflight_d = 1'b1;
        sb_inf_d   = sb_iss_q;
      end else if (push) begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      win_q      <= '0;
      addr_q     <= '0;
      fcnt_q     <= '0;
      issued_q   <= 1'b0;
      sb_iss_q   <= '0;
      inflight_q <= 1'b0;
      sb_inf_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      fcnt_q     <= fcnt_d;
      issued_q   <= issued_d;
      sb_iss_q   <= sb_iss_d;
      inflight_q <= inflight_d;
      sb_inf_q   <= sb_inf_d;
    end
  end

  ref_skid_fifo2 #(
    .WIDTH(FW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(abort_i),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i({sb_inf_q, rom_data_i}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  assign rom_addr_o  = addr_q;
  assign m_valid_o   = !fifo_empty;
  assign m_data_o    = m_valid_o ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign m_sof_o     = m_valid_o && fifo_rdata[DATA_WIDTH+SB_SOF];
  assign m_last_o    = m_valid_o && fifo_rdata[DATA_WIDTH+SB_LAST];
  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_fft_ref_stream_ctrl.sv
// Directed bench for fft_ref_stream_ctrl: one single-frame instance and one
// three-frame instance whose 16-word ROM forces address wrap.
module tb_fft_ref_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic        ready1, ready3;

  logic [3:0]  addr1, addr3;
  logic [31:0] rom1, rom3;
  logic [31:0] data1, data3;
  logic        valid1, valid3, sof1, sof3, last1, last3;
  logic        busy1, busy3, done1, done3;
  logic [15:0] fcnt1, fcnt3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Golden ROM models: ROM[i] = i, one-cycle registered read.
  always_ff @(posedge clk) rom1 <= {28'd0, addr1};
  always_ff @(posedge clk) rom3 <= {28'd0, addr3};

  fft_ref_stream_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .FRAME_LEN(8), .NUM_FRAMES(1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .rom_addr_o(addr1), .rom_data_i(rom1), .m_data_o(data1), .m_valid_o(valid1),
    .m_ready_i(ready1), .m_sof_o(sof1), .m_last_o(last1), .busy_o(busy1),
    .done_o(done1), .frame_cnt_o(fcnt1)
  );

  fft_ref_stream_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .FRAME_LEN(8), .NUM_FRAMES(3)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .rom_addr_o(addr3), .rom_data_i(rom3), .m_data_o(data3), .m_valid_o(valid3),
    .m_ready_i(ready3), .m_sof_o(sof3), .m_last_o(last3), .busy_o(busy3),
    .done_o(done3), .frame_cnt_o(fcnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; abort = 1'b0; ready1 = 1'b1; ready3 = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({valid1, sof1, last1, busy1, done1} !== 5'b0 || data1 !== 32'd0 || fcnt1 !== 16'd0 || addr1 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_state actual v/s/l/b/d=%b%b%b%b%b data=%0h fcnt=%0d addr=%0d required all zero",
               valid1, sof1, last1, busy1, done1, data1, fcnt1, addr1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    ready1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL single_busy actual=%b required=1", busy1); end
    tick();
    checks++;
    if (addr1 !== 4'd0) begin failures++; $display("[TB] FAIL single_first_addr actual=%0d required=0", addr1); end
    checks++;
    if (valid1 !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_n1 actual=%b required=0", valid1); end
    tick();
    checks++;
    if (valid1 !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_n2 actual=%b required=0", valid1); end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (valid1 !== 1'b1 || data1 !== 32'(k) || sof1 !== (k == 0) || last1 !== (k == 7)) begin
        failures++;
        $display("[TB] FAIL single_beat%0d actual v=%b d=%0d sof=%b last=%b required v=1 d=%0d sof=%b last=%b",
                 k, valid1, data1, sof1, last1, k, (k == 0), (k == 7));
      end
      tick();
    end
    checks++;
    if (done1 !== 1'b1 || fcnt1 !== 16'd1 || valid1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_done actual done=%b fcnt=%0d v=%b required done=1 fcnt=1 v=0", done1, fcnt1, valid1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_after_done actual done=%b busy=%b required 0 0", done1, busy1);
    end
  endtask

  task automatic test_backpressure();
    int          idx = 0;
    bit          stalled = 1'b0;
    bit          seen_done = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_s = 1'b0;
    logic        hold_l = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (stalled) begin
        checks++;
        if (valid1 !== 1'b1 || data1 !== hold_d || sof1 !== hold_s || last1 !== hold_l) begin
          failures++;
          $display("[TB] FAIL bp_stable actual v=%b d=%0d sof=%b last=%b required v=1 d=%0d sof=%b last=%b",
                   valid1, data1, sof1, last1, hold_d, hold_s, hold_l);
        end
      end
      if (done1 === 1'b1) seen_done = 1'b1;
      ready1  = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (valid1 === 1'b1) begin
        if (ready1) begin
          checks++;
          if (data1 !== 32'(idx) || sof1 !== (idx == 0) || last1 !== (idx == 7)) begin
            failures++;
            $display("[TB] FAIL bp_beat%0d actual d=%0d sof=%b last=%b required d=%0d sof=%b last=%b",
                     idx, data1, sof1, last1, idx, (idx == 0), (idx == 7));
          end
          idx++;
        end else begin
          stalled = 1'b1;
          hold_d  = data1;
          hold_s  = sof1;
          hold_l  = last1;
        end
      end
      tick();
    end
    ready1 = 1'b1;
    checks++;
    if (!seen_done || idx != 8 || fcnt1 !== 16'd1) begin
      failures++;
      $display("[TB] FAIL bp_summary actual done=%0d beats=%0d fcnt=%0d required done=1 beats=8 fcnt=1", seen_done, idx, fcnt1);
    end
  endtask

  task automatic test_multi_frame_wrap();
    int idx = 0;
    int sofs = 0;
    int lasts = 0;
    bit seen_done = 1'b0;
    do_reset();
    ready1 = 1'b1; ready3 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      if (done3 === 1'b1) seen_done = 1'b1;
      if (valid3 === 1'b1) begin
        checks++;
        if (data3 !== 32'(idx % 16) || sof3 !== (idx % 8 == 0) || last3 !== (idx % 8 == 7)) begin
          failures++;
          $display("[TB] FAIL wrap_beat%0d actual d=%0d sof=%b last=%b required d=%0d sof=%b last=%b",
                   idx, data3, sof3, last3, idx % 16, (idx % 8 == 0), (idx % 8 == 7));
        end
        if (sof3) sofs++;
        if (last3) lasts++;
        idx++;
      end
      tick();
    end
    checks++;
    if (!seen_done || idx != 24 || sofs != 3 || lasts != 3 || fcnt3 !== 16'd3) begin
      failures++;
      $display("[TB] FAIL wrap_summary actual done=%0d beats=%0d sof=%0d last=%0d fcnt=%0d required 1 24 3 3 3",
               seen_done, idx, sofs, lasts, fcnt3);
    end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int dones = 0;
    int idx = 0;
    bit seen_done = 1'b0;
    ready1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (valid1 === 1'b1 && data1 === 32'd4) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL abort_reach_beat4 actual=0 required=1"); end
    ready1 = 1'b0;
    tick();
    checks++;
    if (valid1 !== 1'b1 || data1 !== 32'd4) begin
      failures++;
      $display("[TB] FAIL abort_stall actual v=%b d=%0d required v=1 d=4", valid1, data1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || fcnt1 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL abort_state actual v=%b busy=%b done=%b fcnt=%0d required 0 0 0 0", valid1, busy1, done1, fcnt1);
    end
    for (int c = 0; c < 6; c++) begin
      if (done1 === 1'b1 || valid1 === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin failures++; $display("[TB] FAIL abort_quiet actual=%0d required=0", dones); end
    ready1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (fcnt1 !== 16'd0 || busy1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_restart actual fcnt=%0d busy=%b required fcnt=0 busy=1", fcnt1, busy1);
    end
    for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
      if (done1 === 1'b1) seen_done = 1'b1;
      if (valid1 === 1'b1) begin
        checks++;
        if (data1 !== 32'(idx) || sof1 !== (idx == 0)) begin
          failures++;
          $display("[TB] FAIL replay_beat%0d actual d=%0d sof=%b required d=%0d sof=%b", idx, data1, sof1, idx, (idx == 0));
        end
        idx++;
      end
      tick();
    end
    checks++;
    if (!seen_done || idx != 8 || fcnt1 !== 16'd1) begin
      failures++;
      $display("[TB] FAIL replay_summary actual done=%0d beats=%0d fcnt=%0d required 1 8 1", seen_done, idx, fcnt1);
    end
  endtask

  task automatic test_start_ignored();
    int beats = 0;
    int extra = 0;
    bit seen_done = 1'b0;
    ready1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (done1 === 1'b1) seen_done = 1'b1;
      if (valid1 === 1'b1) beats++;
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      if (valid1 === 1'b1 || busy1 === 1'b1) extra++;
      tick();
    end
    checks++;
    if (!seen_done || beats != 8 || extra != 0) begin
      failures++;
      $display("[TB] FAIL start_in_fetch actual done=%0d beats=%0d extra=%0d required 1 8 0", seen_done, beats, extra);
    end
    extra = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL start_abort_busy actual=%b required=0", busy1); end
    for (int c = 0; c < 6; c++) begin
      if (valid1 === 1'b1 || busy1 === 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin failures++; $display("[TB] FAIL start_abort_quiet actual=%0d required=0", extra); end
  endtask

  task automatic test_reset_midstream();
    ready1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (valid1 !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_valid actual=%b required=1", valid1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid1, sof1, last1, busy1, done1} !== 5'b0 || data1 !== 32'd0 || fcnt1 !== 16'd0 || addr1 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset actual v/s/l/b/d=%b%b%b%b%b data=%0h fcnt=%0d addr=%0d required all zero",
               valid1, sof1, last1, busy1, done1, data1, fcnt1, addr1);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_after_release actual v=%b busy=%b required 0 0", valid1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_multi_frame_wrap();
    test_abort();
    test_start_ignored();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
